// File: rtl/hub75_bcm_driver.sv
// rtl/hub75_bcm_driver.sv - HUB75 scan driver with binary-code-modulated colour depth
// Shifts one bit plane per pass, latches it, then shows it for a window weighted 1:2:4:...
module hub75_bcm_driver #(
    parameter int COLS     = 64,
    parameter int ROW_BITS = 4,
    parameter int DEPTH    = 4,
    parameter int RD_LAT   = 1,
    parameter int BASE_ON  = 8,
    parameter int BLANK    = 2,
    localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int DW      = 3 * DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic                pix_req,
    output logic [CW-1:0]       pix_col,
    output logic [ROW_BITS-1:0] pix_row,
    input  logic [DW-1:0]       pix_top,
    input  logic [DW-1:0]       pix_bot,
    output logic                r0,
    output logic                g0,
    output logic                b0,
    output logic                r1,
    output logic                g1,
    output logic                b1,
    output logic                sclk,
    output logic                lat,
    output logic                oe,
    output logic [ROW_BITS-1:0] addr,
    output logic                frame_start,
    output logic                busy
);
    localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SHIFT_LEN = 2 * COLS + 2;
    localparam int SW        = $clog2(SHIFT_LEN);
    localparam int SHOW_MAX  = BASE_ON << (DEPTH - 1);
    localparam int WIN_MAX   = (SHOW_MAX > BLANK) ? SHOW_MAX : BLANK;
    localparam int WW        = $clog2(WIN_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_LATCH, S_SHOW, S_BLANK} state_t;

    state_t              state_q, state_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [PW-1:0]       plane_q, plane_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic [WW-1:0]       win_q, win_d;
    logic [DW-1:0]       cap_top_q, cap_top_d, cap_bot_q, cap_bot_d;
    logic [5:0]          rgb_q, rgb_d;
    logic                pix_req_q, pix_req_d, sclk_q, sclk_d, lat_q, lat_d;
    logic                oe_q, oe_d, fs_q, fs_d, busy_q, busy_d;
    logic [CW-1:0]       pix_col_q, pix_col_d;
    logic [ROW_BITS-1:0] pix_row_q, pix_row_d, addr_q, addr_d;

    logic [DW-1:0]       src_top, src_bot;
    logic [DEPTH-1:0]    tr, tg, tb, br, bg, bb;
    logic                load_rgb;

    // With zero latency the pixel arrives in the request cycle, so it is held one cycle
    assign src_top = (RD_LAT == 0) ? cap_top_q : pix_top;
    assign src_bot = (RD_LAT == 0) ? cap_bot_q : pix_bot;
    assign tr = src_top[3*DEPTH-1 -: DEPTH];
    assign tg = src_top[2*DEPTH-1 -: DEPTH];
    assign tb = src_top[DEPTH-1:0];
    assign br = src_bot[3*DEPTH-1 -: DEPTH];
    assign bg = src_bot[2*DEPTH-1 -: DEPTH];
    assign bb = src_bot[DEPTH-1:0];
    assign load_rgb = (state_q == S_SHIFT) && slot_q[0] && (slot_q < SW'(2 * COLS));

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        plane_d   = plane_q;
        slot_d    = slot_q;
        win_d     = win_q;
        addr_d    = addr_q;
        cap_top_d = cap_top_q;
        cap_bot_d = cap_bot_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_SHIFT;
                    row_d   = '0;
                    plane_d = '0;
                    slot_d  = '0;
                end
            end
            S_SHIFT: begin
                if (!slot_q[0]) begin
                    cap_top_d = pix_top;
                    cap_bot_d = pix_bot;
                end
                if (slot_q == SW'(SHIFT_LEN - 1)) begin
                    state_d = S_LATCH;
                    addr_d  = row_q;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            S_LATCH: begin
                state_d = S_SHOW;
                win_d   = WW'((BASE_ON << plane_q) - 1);
            end
            S_SHOW: begin
                if (win_q == '0) begin
                    state_d = S_BLANK;
                    win_d   = WW'(BLANK - 1);
                end else begin
                    win_d = win_q - 1'b1;
                end
            end
            S_BLANK: begin
                if (win_q == '0) begin
                    if (plane_q == PW'(DEPTH - 1)) begin
                        plane_d = '0;
                        row_d   = row_q + 1'b1;
                    end else begin
                        plane_d = plane_q + 1'b1;
                    end
                    slot_d  = '0;
                    state_d = en ? S_SHIFT : S_IDLE;
                end else begin
                    win_d = win_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_rgb)
            rgb_d = {tr[plane_q], tg[plane_q], tb[plane_q], br[plane_q], bg[plane_q], bb[plane_q]};
        else if (state_d == S_SHIFT)
            rgb_d = rgb_q;
        else
            rgb_d = '0;

        // Outputs are decoded from the next state so each registered pin lines up with its state
        pix_req_d = (state_d == S_SHIFT) && !slot_d[0] && (slot_d < SW'(2 * COLS));
        pix_col_d = (state_d == S_SHIFT) ? CW'(slot_d >> 1) : '0;
        pix_row_d = (state_d == S_SHIFT) ? row_d : '0;
        sclk_d    = (state_d == S_SHIFT) && slot_d[0] && (slot_d >= SW'(3));
        lat_d     = (state_d == S_LATCH);
        oe_d      = (state_d != S_SHOW);
        busy_d    = (state_d != S_IDLE);
        fs_d      = (state_d == S_SHIFT) && (slot_d == '0) && (row_d == '0) && (plane_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            plane_q   <= '0;
            slot_q    <= '0;
            win_q     <= '0;
            cap_top_q <= '0;
            cap_bot_q <= '0;
            rgb_q     <= '0;
            pix_req_q <= 1'b0;
            pix_col_q <= '0;
            pix_row_q <= '0;
            sclk_q    <= 1'b0;
            lat_q     <= 1'b0;
            oe_q      <= 1'b1;
            addr_q    <= '0;
            fs_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            plane_q   <= plane_d;
            slot_q    <= slot_d;
            win_q     <= win_d;
            cap_top_q <= cap_top_d;
            cap_bot_q <= cap_bot_d;
            rgb_q     <= rgb_d;
            pix_req_q <= pix_req_d;
            pix_col_q <= pix_col_d;
            pix_row_q <= pix_row_d;
            sclk_q    <= sclk_d;
            lat_q     <= lat_d;
            oe_q      <= oe_d;
            addr_q    <= addr_d;
            fs_q      <= fs_d;
            busy_q    <= busy_d;
        end
    end

    assign {r0, g0, b0, r1, g1, b1} = rgb_q;
    assign pix_req     = pix_req_q;
    assign pix_col     = pix_col_q;
    assign pix_row     = pix_row_q;
    assign sclk        = sclk_q;
    assign lat         = lat_q;
    assign oe          = oe_q;
    assign addr        = addr_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_hub75_bcm_driver.sv
// tb/tb_hub75_bcm_driver.sv - bench for hub75_bcm_driver, RD_LAT=1 and RD_LAT=0 copies in lockstep
module tb_hub75_bcm_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    always #5 clk = ~clk;

    logic       req_a, req_b, r0_a, g0_a, b0_a, r1_a, g1_a, b1_a, r0_b, g0_b, b0_b, r1_b, g1_b, b1_b;
    logic       sclk_a, sclk_b, lat_a, lat_b, oe_a, oe_b, fs_a, fs_b, busy_a, busy_b;
    logic [1:0] col_a, col_b;
    logic       prow_a, prow_b, addr_a, addr_b;
    logic [5:0] top_a, bot_a, top_b, bot_b;

    function automatic logic [5:0] top_pix(input logic [1:0] c);
        return {c, ~c, 2'b00};
    endfunction
    function automatic logic [5:0] bot_pix(input logic r);
        return {4'b0000, (r ? 2'b10 : 2'b01)};
    endfunction

    always @(posedge clk) begin
        top_a <= top_pix(col_a);
        bot_a <= bot_pix(prow_a);
    end
    assign top_b = top_pix(col_b);
    assign bot_b = bot_pix(prow_b);

    hub75_bcm_driver #(.COLS(4), .ROW_BITS(1), .DEPTH(2), .RD_LAT(1), .BASE_ON(2), .BLANK(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .pix_req(req_a), .pix_col(col_a), .pix_row(prow_a),
        .pix_top(top_a), .pix_bot(bot_a), .r0(r0_a), .g0(g0_a), .b0(b0_a), .r1(r1_a), .g1(g1_a),
        .b1(b1_a), .sclk(sclk_a), .lat(lat_a), .oe(oe_a), .addr(addr_a), .frame_start(fs_a),
        .busy(busy_a));

    hub75_bcm_driver #(.COLS(4), .ROW_BITS(1), .DEPTH(2), .RD_LAT(0), .BASE_ON(2), .BLANK(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .pix_req(req_b), .pix_col(col_b), .pix_row(prow_b),
        .pix_top(top_b), .pix_bot(bot_b), .r0(r0_b), .g0(g0_b), .b0(b0_b), .r1(r1_b), .g1(g1_b),
        .b1(b1_b), .sclk(sclk_b), .lat(lat_b), .oe(oe_b), .addr(addr_b), .frame_start(fs_b),
        .busy(busy_b));

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Panel-side observer
    int cyc = 0;
    int viol = 0;
    int sclk_cnt = 0;
    int oe_run = 0;
    logic prev_addr = 1'b0;
    int fs_cyc[$];
    int lat_cyc[$];
    int lat_addr[$];
    int sclk_hist[$];
    int oe_runs[$];

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_addr = addr_a;
                oe_run    = 0;
                sclk_cnt  = 0;
            end else begin
                if ((lat_a && !oe_a) || (lat_b && !oe_b)) viol++;
                if (addr_a != prev_addr && !(lat_a && oe_a)) viol++;
                prev_addr = addr_a;
                if (fs_a) fs_cyc.push_back(cyc);
                if (lat_a) begin
                    lat_cyc.push_back(cyc);
                    lat_addr.push_back(int'(addr_a));
                    sclk_hist.push_back(sclk_cnt);
                    sclk_cnt = 0;
                end
                if (sclk_a) sclk_cnt++;
                if (!oe_a) oe_run++;
                else if (oe_run > 0) begin
                    oe_runs.push_back(oe_run);
                    oe_run = 0;
                end
            end
            cyc++;
        end
    end

    typedef struct {
        int         row;
        int         plane;
        int         col;
        logic [2:0] exp_rgb;
    } vec_t;
    vec_t vec [16];

    initial begin
        int n;
        vec = '{
            '{0, 0, 0, 3'b011}, '{0, 0, 1, 3'b101}, '{0, 0, 2, 3'b011}, '{0, 0, 3, 3'b101},
            '{0, 1, 0, 3'b010}, '{0, 1, 1, 3'b010}, '{0, 1, 2, 3'b100}, '{0, 1, 3, 3'b100},
            '{1, 0, 0, 3'b010}, '{1, 0, 1, 3'b100}, '{1, 0, 2, 3'b010}, '{1, 0, 3, 3'b100},
            '{1, 1, 0, 3'b011}, '{1, 1, 1, 3'b011}, '{1, 1, 2, 3'b101}, '{1, 1, 3, 3'b101}
        };

        tick();
        tick();
        check("rst_oe", oe_a, 1);
        check("rst_lat", lat_a, 0);
        check("rst_sclk", sclk_a, 0);
        check("rst_rgb", {r0_a, g0_a, b0_a, r1_a, g1_a, b1_a}, 0);
        check("rst_addr", addr_a, 0);
        check("rst_req", req_a, 0);
        check("rst_col_row", {col_a, prow_a}, 0);
        check("rst_fs_busy", {fs_a, busy_a}, 0);

        rst = 1'b0;
        tick();
        tick();
        check("idle_busy", busy_a, 0);

        en = 1'b1;
        tick();
        check("start_req", req_a, 1);
        check("start_fs", fs_a, 1);
        check("start_col_row", {col_a, prow_a}, 0);
        check("start_busy_oe", {busy_a, oe_a}, 3);

        for (int i = 0; i < 16; i++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!sclk_a && n < 100);
            check($sformatf("vec%0d_sclk", i), sclk_a, 1);
            check($sformatf("vec%0d_a_r%0d_p%0d_c%0d", i, vec[i].row, vec[i].plane, vec[i].col),
                  {prow_a, r0_a, g0_a, b1_a}, {vec[i].row[0], vec[i].exp_rgb});
            check($sformatf("vec%0d_b_r%0d_p%0d_c%0d", i, vec[i].row, vec[i].plane, vec[i].col),
                  {prow_b, r0_b, g0_b, b1_b}, {vec[i].row[0], vec[i].exp_rgb});
        end

        n = 0;
        while (fs_cyc.size() < 3 && n < 300) begin
            tick();
            n++;
        end
        check("fs_seen3", fs_cyc.size() >= 3, 1);
        check("frame_period0", (fs_cyc.size() > 1) ? fs_cyc[1] - fs_cyc[0] : -1, 60);
        check("frame_period1", (fs_cyc.size() > 2) ? fs_cyc[2] - fs_cyc[1] : -1, 60);
        check("fs_to_lat", (lat_cyc.size() > 0) ? lat_cyc[0] - fs_cyc[0] : -1, 10);
        check("plane_period0", (lat_cyc.size() > 1) ? lat_cyc[1] - lat_cyc[0] : -1, 14);
        check("plane_period1", (lat_cyc.size() > 2) ? lat_cyc[2] - lat_cyc[1] : -1, 16);
        check("plane_period2", (lat_cyc.size() > 3) ? lat_cyc[3] - lat_cyc[2] : -1, 14);
        for (int i = 0; i < 6; i++)
            check($sformatf("lat_addr%0d", i), (lat_addr.size() > i) ? lat_addr[i] : -1, (i / 2) % 2);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sclk_per_shift%0d", i), (sclk_hist.size() > i) ? sclk_hist[i] : -1, 4);
            check($sformatf("oe_run%0d", i), (oe_runs.size() > i) ? oe_runs[i] : -1, (i % 2) ? 4 : 2);
        end

        // Drop en two cycles into the SHOW of row 1 plane 1
        n = 0;
        while (lat_cyc.size() < 12 && n < 300) begin
            tick();
            n++;
        end
        check("r1p1_lat", {lat_a, addr_a}, 3);
        tick();
        tick();
        check("r1p1_show", oe_a, 0);
        en = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy_a && n < 20);
        check("en_drop_to_idle", n, 4);
        check("idle_oe_addr", {oe_a, addr_a}, 3);
        tick();
        tick();
        check("idle_stays", {busy_a, req_a}, 0);
        en = 1'b1;
        tick();
        check("reen_fs_row", {fs_a, prow_a, req_a}, 3'b101);

        // Reset in the middle of a row-1 SHOW window
        n = 0;
        while (!(oe_a == 1'b0 && addr_a == 1'b1) && n < 200) begin
            tick();
            n++;
        end
        check("show_row1_seen", {oe_a, addr_a}, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst", {oe_a, lat_a, addr_a, busy_a}, 4'b1000);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("restart_fs_row", {fs_a, prow_a, busy_a}, 3'b101);

        check("lat_oe_addr_rules", viol, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
